// File: rtl/hpdmc_initseq_pkg.sv
// hpdmc_initseq_pkg: command nibbles, CSR addresses, FSM states and SDRAM word packing.
package hpdmc_initseq_pkg;
  localparam logic [3:0] CMD_PRECHARGE = 4'b1011;
  localparam logic [3:0] CMD_LMR = 4'b1111;
  localparam logic [3:0] CMD_REFRESH = 4'b1101;
  localparam logic [31:0] CSR_CTRL = 32'h0;
  localparam logic [31:0] CSR_BYPASS = 32'h4;
  localparam logic [3:0] LAST_STEP = 4'd8;
  typedef enum logic [2:0] {S_POWERUP, S_ISSUE, S_GAP, S_DONE, S_ERROR} state_t;
  function automatic logic [31:0] sdram_word(input logic [1:0] ba, input logic [12:0] a, input logic [3:0] cmd);
    return {13'b0, ba, a, cmd};
  endfunction
endpackage

// File: rtl/hpdmc_initseq_rom.sv
// hpdmc_initseq_rom: init step table, index -> CSR address, data word and post-write gap.
module hpdmc_initseq_rom
  import hpdmc_initseq_pkg::*;
#(
  parameter int T_RP = 2,
  parameter int T_RFC = 8,
  parameter int T_DLL = 200,
  parameter logic [2:0] CL_CODE = 3'b010
) (
  input  logic [3:0]  idx,
  output logic [31:0] adr,
  output logic [31:0] dat,
  output logic [23:0] gap
);
  // MR: A8 = DLL reset, A6-A4 = CAS latency, A2-A0 = burst length 8
  localparam logic [31:0] MR_DLL_RST = sdram_word(2'b00, {4'b0, 1'b1, 1'b0, CL_CODE, 4'b0011}, CMD_LMR);
  localparam logic [31:0] MR_NORMAL = sdram_word(2'b00, {4'b0, 1'b0, 1'b0, CL_CODE, 4'b0011}, CMD_LMR);
  localparam logic [31:0] PRECHARGE_ALL = sdram_word(2'b00, 13'h0400, CMD_PRECHARGE);
  localparam logic [31:0] EMR = sdram_word(2'b01, 13'h0000, CMD_LMR);
  localparam logic [31:0] REFRESH = sdram_word(2'b00, 13'h0000, CMD_REFRESH);
  always_comb begin
    adr = CSR_BYPASS;
    dat = 32'h0;
    gap = 24'd0;
    case (idx)
      4'd0: begin adr = CSR_CTRL; dat = 32'h7; end
      4'd1, 4'd4: begin dat = PRECHARGE_ALL; gap = 24'(T_RP); end
      4'd2: begin dat = EMR; gap = 24'(T_RP); end
      4'd3: begin dat = MR_DLL_RST; gap = 24'(T_DLL); end
      4'd5, 4'd6: begin dat = REFRESH; gap = 24'(T_RFC); end
      4'd7: begin dat = MR_NORMAL; gap = 24'(T_DLL); end
      default: begin adr = CSR_CTRL; dat = 32'h4; end
    endcase
  end
endmodule

// File: rtl/hpdmc_initseq.sv
// hpdmc_initseq: autonomous SDRAM power-up sequencer driving the HPDMC CSR bus in bypass mode.
module hpdmc_initseq
  import hpdmc_initseq_pkg::*;
#(
  parameter int T_POWERUP = 20000,
  parameter int T_RP = 2,
  parameter int T_RFC = 8,
  parameter int T_DLL = 200,
  parameter logic [2:0] CL_CODE = 3'b010,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  output logic [31:0] wbc_adr_o,
  output logic [31:0] wbc_dat_o,
  output logic        wbc_cyc_o,
  output logic        wbc_stb_o,
  output logic        wbc_we_o,
  input  logic        wbc_ack_i,
  output logic        busy,
  output logic        done,
  output logic        error
);
  localparam logic [7:0] T_LAST = 8'(ACK_TIMEOUT - 1);
  state_t state;
  logic [23:0] cnt;
  logic [7:0] tcnt;
  logic [3:0] idx;
  logic [3:0] rom_idx;
  logic [31:0] r_adr, r_dat;
  logic [23:0] r_gap;
  // In GAP the table is read one step ahead so the next write loads directly
  assign rom_idx = state == S_GAP ? idx + 4'd1 : idx;
  assign wbc_cyc_o = wbc_stb_o;
  assign wbc_we_o = wbc_stb_o;
  hpdmc_initseq_rom #(
    .T_RP(T_RP),
    .T_RFC(T_RFC),
    .T_DLL(T_DLL),
    .CL_CODE(CL_CODE)
  ) rom (
    .idx(rom_idx),
    .adr(r_adr),
    .dat(r_dat),
    .gap(r_gap)
  );
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      state <= S_POWERUP;
      cnt <= 24'(T_POWERUP);
      tcnt <= 8'd0;
      idx <= 4'd0;
      wbc_adr_o <= 32'h0;
      wbc_dat_o <= 32'h0;
      wbc_stb_o <= 1'b0;
      busy <= 1'b1;
      done <= 1'b0;
      error <= 1'b0;
    end else
      case (state)
        S_POWERUP, S_GAP:
          if (cnt == 24'd0) begin
            state <= S_ISSUE;
            idx <= rom_idx;
            wbc_adr_o <= r_adr;
            wbc_dat_o <= r_dat;
            wbc_stb_o <= 1'b1;
            tcnt <= 8'd0;
          end else cnt <= cnt - 24'd1;
        S_ISSUE:
          if (wbc_ack_i) begin
            wbc_stb_o <= 1'b0;
            cnt <= r_gap;
            state <= idx == LAST_STEP ? S_DONE : S_GAP;
            busy <= idx != LAST_STEP;
            done <= idx == LAST_STEP;
          end else if (tcnt == T_LAST) begin
            wbc_stb_o <= 1'b0;
            state <= S_ERROR;
            busy <= 1'b0;
            error <= 1'b1;
          end else tcnt <= tcnt + 8'd1;
        default: ;
      endcase
endmodule
